// File: rtl/mmm_ctrl_pkg.sv
// mmm_ctrl shared definitions.
// State set and counter sizing helper.
package mmm_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_LOAD    = 3'd2,
      S_RUN     = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mmm_ctrl_if.sv
// Control/handshake bundle between host, sequencer and
// the Montgomery multiplier datapath.
interface mmm_ctrl_if;
   logic ena;
   logic start;
   logic abort;
   logic en_mmm;
   logic rst_mmm;
   logic ld_a;
   logic ld_r;
   logic lock;
   logic busy;
   logic done;

   modport master (
      output ena, start, abort,
      input  en_mmm, rst_mmm, ld_a, ld_r,
      input  lock, busy, done
   );

   modport slave (
      input  ena, start, abort,
      output en_mmm, rst_mmm, ld_a, ld_r,
      output lock, busy, done
   );
endinterface

// File: rtl/mmm_iter_counter.sv
// Loadable down-counter with enable and zero flag.
// Saturates at zero instead of wrapping.
module mmm_iter_counter #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] init,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= init;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mmm_ctrl.sv
// Sequencer for the Montgomery multiplier datapath:
// clear, load A, WIDTH iterations, capture, done.
module mmm_ctrl
   import mmm_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rstb,
   mmm_ctrl_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   localparam logic [2:0] IDLE    = S_IDLE;
   localparam logic [2:0] CLEAR   = S_CLEAR;
   localparam logic [2:0] LOAD    = S_LOAD;
   localparam logic [2:0] RUN     = S_RUN;
   localparam logic [2:0] CAPTURE = S_CAPTURE;
   localparam logic [2:0] DONE    = S_DONE;

   logic [2:0] state;
   logic [2:0] state_nx;
   logic       cnt_zero;
   logic       in_op;

   mmm_iter_counter #(
      .CW (CW)
   ) u_cnt (
      .clk  (clk),
      .rstb (rstb),
      .load (bus.ena && state == LOAD),
      .dec  (bus.ena && state == RUN),
      .init (CNT_INIT),
      .zero (cnt_zero)
   );

   // abort overrides every transition, including a start in DONE
   always_comb begin
      state_nx = state;
      if (bus.abort) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (bus.start) state_nx = CLEAR;
            CLEAR:   state_nx = LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (cnt_zero) state_nx = CAPTURE;
            CAPTURE: state_nx = DONE;
            DONE:    state_nx = bus.start ? CLEAR : IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= IDLE;
      end else if (bus.ena) begin
         state <= state_nx;
      end
   end

   assign in_op = (state == CLEAR) || (state == LOAD) ||
                  (state == RUN)   || (state == CAPTURE);

   assign bus.busy    = in_op;
   assign bus.en_mmm  = bus.ena && in_op;
   assign bus.rst_mmm = (state != CLEAR);
   assign bus.ld_a    = (state == LOAD);
   assign bus.ld_r    = (state == CAPTURE);
   assign bus.lock    = (state != CAPTURE);
   assign bus.done    = (state == DONE);

endmodule
